vga_stream_out: RTL and testbench
=================================

# vga_stream_out

Parametrised VGA output stage that replaces the fixed 640x480 VGA component on the Nios system bus. It takes an RGB pixel stream (valid/ready, start-of-frame marker) into an internal show-ahead FIFO. It generates HS/VS timing from a configurable pixel-clock divider and drives registered colour and sync pins. Unlike the previous component it adds:

- configurable resolution, porches and sync polarity
- configurable colour width
- underflow detection and fill colour
- automatic frame resynchronisation on the start-of-frame marker

## Interface

Parameters:

- COLOR_W, 8: bits per colour channel
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines
- HS_POL, 0 / VS_POL, 0: sync active level
- CLK_DIV, 2: clk_clk cycles per pixel (≥1)
- FIFO_DEPTH, 16: pixel FIFO entries (power of 2, ≥4)
- FILL_COLOR, 0: {R,G,B} driven on underflow or desync

Ports:

- clk_clk  in  1  single clock
- reset_reset_n  in  1  synchronous, active-low reset
- enable  in  1  0 = output idle, FIFO flushed
- pix_data  in  3*COLOR_W  {R,G,B}, R in MSBs
- pix_sop  in  1  marks pixel (0,0) of a frame
- pix_valid  in  1  source word valid
- pix_ready  out  1  FIFO can accept; write = valid & ready
- redoutput / greenoutput / blueoutput  out  COLOR_W each  colour pins
- hsoutput / vsoutput  out  1  sync pins
- frame_start  out  1  one-clock pulse when pixel (0,0) is output
- underflow  out  1  sticky; set on empty FIFO in active region
- underflow_clr  in  1  clears underflow (set wins if simultaneous)

## Operation

**Totals**
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL similarly.
- h_cnt and v_cnt are $clog2(TOTAL) bits wide.

**Counters**
- The divider counts 0..CLK_DIV-1. tick = (div == CLK_DIV-1); with CLK_DIV=1, tick is always 1.
- On tick, h_cnt increments and wraps at H_TOTAL-1. v_cnt increments on the h_cnt wrap and wraps at V_TOTAL-1.
- Region order: active, front porch, sync, back porch.
- hs is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs uses the same rule on v_cnt.
- active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. Colour outside the active region is 0.

**FIFO**
- Show-ahead; stores {sop,data}.
- pix_ready = !full && enable && reset_reset_n.

**State machine**
- IDLE
  - Entered on reset or enable=0. Counters, divider and FIFO are held at 0.
  - On enable=1, go to RESYNC.
- RESYNC
  - Counters run. Active pixels output FILL_COLOR.
  - Each clock, if the head has sop=0 it is popped (one per clock, independent of tick).
  - When the head has sop=1, go to WAIT.
- WAIT
  - Counters run; nothing is popped.
  - On the tick where (h_cnt,v_cnt)=(0,0), go to RUN and output that pixel.
- RUN
  - On each active tick, pop the head and output it.
  - Empty FIFO: output FILL_COLOR, set underflow, do not pop, stay in RUN.
  - At (0,0), head sop=0: output FILL_COLOR, go to RESYNC.
  - At any other active position, head sop=1: do not pop, output FILL_COLOR, go to WAIT.
- underflow is set only in RUN.
- enable falling in any state → IDLE next clock. Outputs take their reset values next clock and the FIFO is flushed.

## Timing

- Reset values:
  - colour = 0, hsoutput = ~HS_POL, vsoutput = ~VS_POL
  - frame_start = 0, underflow = 0, pix_ready = 0
  - state = IDLE, counters = 0
- All outputs are registered. Colour, hs, vs and frame_start for position (h,v) update on the clock edge ending that position's tick cycle. This gives one clock of latency, identical for all pins.
- frame_start pulses with the (0,0) output in RUN, or on entry from WAIT.
- FIFO write-to-readable latency: 1 clock (a word written at edge n is head at n+1).
- Simultaneous push and pop when full: the pop frees space, but pix_ready is computed from the registered count and stays 0 that clock.
- Reset asserted mid-frame returns everything to reset values on the next edge.

## Structure

- Package vga_pkg holds:
  - the state enum {IDLE, RESYNC, WAIT, RUN}
  - a timing struct with helper functions for totals and sync-window bounds
  - the default 640x480@60 constants
- Sub-module vga_pixel_fifo: parametrised width/depth, show-ahead, synchronous flush, outputs full/empty.
- Top level contains the divider, counters, FSM and output registers.

## Test plan

Small-resolution runs use H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=2, FIFO_DEPTH=8.

1. **Sync timing.** Default parameters, enable=1, no pixels. Expect:
   - hsoutput low for exactly 192 clocks every 1600.
   - vsoutput low for 2 lines every 525 lines.
   - All colour = FILL_COLOR in active, 0 elsewhere.
   - underflow stays 0, since the FSM never reaches RUN.
2. **Ordered frame.** Small resolution; stream two frames of pixel values 0..11 with sop on the first pixel. Expect:
   - colours 0..11 in raster order.
   - frame_start pulse once per frame.
   - no underflow.
3. **Underflow.** Small resolution; supply only 10 pixels of a frame. Expect:
   - the last 2 active pixels = FILL_COLOR.
   - underflow=1, held until underflow_clr.
   - the next frame's sop pixel realigns at (0,0).
4. **Resync.** Small resolution; push 3 non-sop words, then a sop frame. Expect:
   - the 3 words are dropped.
   - the first frame output is FILL_COLOR.
   - the sop frame appears exactly at the next (0,0).
5. **Early sop.** Small resolution; insert sop at pixel index 5 mid-frame. Expect:
   - pixels 5..11 = FILL_COLOR.
   - the sop word is output at the next (0,0).
6. **Enable / reset mid-frame.** Drop enable at v_cnt=1, or pull reset_reset_n low at v_cnt=1. Expect:
   - next clock, all outputs at reset values and pix_ready=0.
   - after re-enable, the first output frame starts at (0,0) with sop data.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared types, default 640x480@60 timing and timing helpers
//               for the VGA stream output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESYNC = 2'd1,
        WAIT   = 2'd2,
        RUN    = 2'd3
    } vga_state_e;

    // One axis of raster timing, regions in output order.
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_axis_t;

    localparam int unsigned c_DEF_H_ACTIVE = 640;
    localparam int unsigned c_DEF_H_FP     = 16;
    localparam int unsigned c_DEF_H_SYNC   = 96;
    localparam int unsigned c_DEF_H_BP     = 48;
    localparam int unsigned c_DEF_V_ACTIVE = 480;
    localparam int unsigned c_DEF_V_FP     = 10;
    localparam int unsigned c_DEF_V_SYNC   = 2;
    localparam int unsigned c_DEF_V_BP     = 33;

    function automatic int unsigned axis_total(input vga_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

    function automatic int unsigned axis_sync_start(input vga_axis_t a);
        return a.active + a.fp;
    endfunction

    function automatic int unsigned axis_sync_end(input vga_axis_t a);
        return a.active + a.fp + a.sync;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_fifo
// Description : Show-ahead FIFO with synchronous flush; head is valid one
//               clock after the write that fills an empty FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/vga_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : vga_stream_out
// Description : Parametrised VGA output stage: pixel FIFO, raster timing,
//               frame alignment on start-of-frame and registered pins.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int unsigned          COLOR_W    = 8,
    parameter int unsigned          H_ACTIVE   = c_DEF_H_ACTIVE,
    parameter int unsigned          H_FP       = c_DEF_H_FP,
    parameter int unsigned          H_SYNC     = c_DEF_H_SYNC,
    parameter int unsigned          H_BP       = c_DEF_H_BP,
    parameter int unsigned          V_ACTIVE   = c_DEF_V_ACTIVE,
    parameter int unsigned          V_FP       = c_DEF_V_FP,
    parameter int unsigned          V_SYNC     = c_DEF_V_SYNC,
    parameter int unsigned          V_BP       = c_DEF_V_BP,
    parameter bit                   HS_POL     = 1'b0,
    parameter bit                   VS_POL     = 1'b0,
    parameter int unsigned          CLK_DIV    = 2,
    parameter int unsigned          FIFO_DEPTH = 16,
    parameter logic [3*COLOR_W-1:0] FILL_COLOR = '0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 enable,
    input  logic [3*COLOR_W-1:0] pix_data,
    input  logic                 pix_sop,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [COLOR_W-1:0]   redoutput,
    output logic [COLOR_W-1:0]   greenoutput,
    output logic [COLOR_W-1:0]   blueoutput,
    output logic                 hsoutput,
    output logic                 vsoutput,
    output logic                 frame_start,
    output logic                 underflow,
    input  logic                 underflow_clr
);
    localparam int unsigned c_PIX_W   = 3*COLOR_W;
    localparam vga_axis_t   c_H_AXIS  = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
    localparam vga_axis_t   c_V_AXIS  = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
    localparam int unsigned c_H_TOTAL = axis_total(c_H_AXIS);
    localparam int unsigned c_V_TOTAL = axis_total(c_V_AXIS);
    localparam int unsigned c_HW      = $clog2(c_H_TOTAL);
    localparam int unsigned c_VW      = $clog2(c_V_TOTAL);
    localparam int unsigned c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_HW-1:0]    c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_VW-1:0]    c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_HW-1:0]    c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_VW-1:0]    c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_HW-1:0]    c_HS_BEG   = c_HW'(axis_sync_start(c_H_AXIS));
    localparam logic [c_VW-1:0]    c_VS_BEG   = c_VW'(axis_sync_start(c_V_AXIS));
    // One bit wider so a window ending exactly at TOTAL still compares correctly
    localparam logic [c_HW:0]      c_HS_END   = (c_HW+1)'(axis_sync_end(c_H_AXIS));
    localparam logic [c_VW:0]      c_VS_END   = (c_VW+1)'(axis_sync_end(c_V_AXIS));

    vga_state_e           r_state;
    vga_state_e           w_state_nxt;
    logic [c_DIV_W-1:0]   r_div;
    logic [c_HW-1:0]      r_h_cnt;
    logic [c_VW-1:0]      r_v_cnt;
    logic                 w_hold;
    logic                 w_tick;
    logic                 w_active;
    logic                 w_origin;
    logic                 w_hs_on;
    logic                 w_vs_on;
    logic                 w_rst;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_PIX_W:0]     w_head;
    logic                 w_head_sop;
    logic [c_PIX_W-1:0]   w_head_data;
    logic [c_PIX_W-1:0]   w_color;
    logic                 w_fs;
    logic                 w_uf_set;

    assign w_rst       = ~reset_reset_n;
    assign pix_ready   = ~w_full & enable & reset_reset_n;
    assign w_push      = pix_valid & pix_ready;
    assign w_head_sop  = w_head[c_PIX_W];
    assign w_head_data = w_head[c_PIX_W-1:0];
    assign w_hold      = ~reset_reset_n | ~enable | (r_state == IDLE);
    assign w_tick      = (r_div == c_DIV_LAST);
    assign w_active    = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_hs_on     = (r_h_cnt >= c_HS_BEG) && ({1'b0, r_h_cnt} < c_HS_END);
    assign w_vs_on     = (r_v_cnt >= c_VS_BEG) && ({1'b0, r_v_cnt} < c_VS_END);

    vga_pixel_fifo #(
        .WIDTH (c_PIX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .rst     (w_rst),
        .i_flush (~enable),
        .i_push  (w_push),
        .i_data  ({pix_sop, pix_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_clk) begin
        if (w_hold) begin
            r_div   <= '0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                if (r_h_cnt == c_H_LAST) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) r_state <= IDLE;
        else                r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_fs        = 1'b0;
        w_uf_set    = 1'b0;
        w_color     = w_active ? FILL_COLOR : '0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = RESYNC;
            end
            RESYNC: begin
                // Drain until a start-of-frame word reaches the head
                if (!w_empty) begin
                    if (w_head_sop) w_state_nxt = WAIT;
                    else            w_pop       = 1'b1;
                end
            end
            WAIT: begin
                if (w_tick && w_origin) begin
                    w_state_nxt = RUN;
                    w_pop       = 1'b1;
                    w_color     = w_head_data;
                    w_fs        = 1'b1;
                end
            end
            RUN: begin
                if (w_tick && w_active) begin
                    if (w_empty) begin
                        w_uf_set = 1'b1;
                    end else if (w_origin) begin
                        if (w_head_sop) begin
                            w_pop   = 1'b1;
                            w_color = w_head_data;
                            w_fs    = 1'b1;
                        end else begin
                            w_state_nxt = RESYNC;
                        end
                    end else if (w_head_sop) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_pop   = 1'b1;
                        w_color = w_head_data;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = IDLE;
            w_pop       = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (w_hold) begin
            redoutput   <= '0;
            greenoutput <= '0;
            blueoutput  <= '0;
            hsoutput    <= ~HS_POL;
            vsoutput    <= ~VS_POL;
            frame_start <= 1'b0;
        end else if (w_tick) begin
            redoutput   <= w_color[c_PIX_W-1 -: COLOR_W];
            greenoutput <= w_color[2*COLOR_W-1 -: COLOR_W];
            blueoutput  <= w_color[COLOR_W-1:0];
            hsoutput    <= w_hs_on ? HS_POL : ~HS_POL;
            vsoutput    <= w_vs_on ? VS_POL : ~VS_POL;
            frame_start <= w_fs;
        end else begin
            frame_start <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || !enable) underflow <= 1'b0;
        else if (w_uf_set)             underflow <= 1'b1;
        else if (underflow_clr)        underflow <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_stream_out
// Description : Self-checking bench for vga_stream_out at a small resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_stream_out;
    localparam int T_HA = 4, T_HF = 1, T_HS = 2, T_HB = 1;
    localparam int T_VA = 3, T_VF = 1, T_VS = 1, T_VB = 1;
    localparam int T_HT = T_HA + T_HF + T_HS + T_HB;
    localparam int T_VT = T_VA + T_VF + T_VS + T_VB;
    localparam int T_DIV = 2, T_DEPTH = 8;
    localparam bit T_HPOL = 1'b0, T_VPOL = 1'b1;
    localparam logic [23:0] T_FILL = 24'hF0E0D0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, en, sop, valid, clr;
    logic [23:0] data;
    logic [7:0]  r, g, b;
    logic        hs, vs, fs, uf, rdy;

    vga_stream_out #(
        .COLOR_W(8), .H_ACTIVE(T_HA), .H_FP(T_HF), .H_SYNC(T_HS), .H_BP(T_HB),
        .V_ACTIVE(T_VA), .V_FP(T_VF), .V_SYNC(T_VS), .V_BP(T_VB),
        .HS_POL(T_HPOL), .VS_POL(T_VPOL), .CLK_DIV(T_DIV), .FIFO_DEPTH(T_DEPTH),
        .FILL_COLOR(T_FILL)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rstn), .enable(en),
        .pix_data(data), .pix_sop(sop), .pix_valid(valid), .pix_ready(rdy),
        .redoutput(r), .greenoutput(g), .blueoutput(b),
        .hsoutput(hs), .vsoutput(vs), .frame_start(fs),
        .underflow(uf), .underflow_clr(clr)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic hs, vs, fs, uf, rdy;
    } obs_t;

    typedef struct {
        int n_words;
        int sop_mask;
        int hold_at;
        int rel_pos;
        int f0_start, f0_n, f1_start, f1_n;
        bit exp_uf;
    } case_t;

    int n_vec = 0, n_bad = 0;

    // Reference model: mode 0 idle, 1 resync, 2 wait, 3 run; raster position
    // is derived arithmetically from clocks elapsed since leaving idle.
    int          m_mode = 0;
    int          m_clk  = 0;
    logic [24:0] m_q[$];
    obs_t        m_o;
    bit          m_push;

    function automatic logic [23:0] wdata(input int i);
        return {8'(16 + i), 8'(64 + i), 8'(128 + i)};
    endfunction

    task automatic model_eval();
        int pos, h, v;
        bit tick, act, org, pop, uf_set, f_s;
        logic [24:0] head;
        logic [23:0] col;
        m_push = valid && (m_q.size() < T_DEPTH) && en && rstn;
        if (!rstn || !en) begin
            m_mode = 0; m_clk = 0; m_q.delete();
            m_o = '{rgb: 24'h0, hs: !T_HPOL, vs: !T_VPOL, fs: 1'b0, uf: 1'b0, rdy: 1'b0};
        end else if (m_mode == 0) begin
            m_mode = 1;
            if (m_push) m_q.push_back({sop, data});
        end else begin
            pos  = m_clk / T_DIV;
            tick = (m_clk % T_DIV) == T_DIV - 1;
            h    = pos % T_HT;
            v    = (pos / T_HT) % T_VT;
            act  = (h < T_HA) && (v < T_VA);
            org  = (h == 0) && (v == 0);
            col  = act ? T_FILL : 24'h0;
            pop = 0; uf_set = 0; f_s = 0;
            head = (m_q.size() > 0) ? m_q[0] : 25'h0;
            if (m_mode == 1) begin
                if (m_q.size() > 0) begin
                    if (head[24]) m_mode = 2; else pop = 1;
                end
            end else if (m_mode == 2) begin
                if (tick && org) begin m_mode = 3; pop = 1; col = head[23:0]; f_s = 1; end
            end else if (tick && act) begin
                if (m_q.size() == 0) uf_set = 1;
                else if (org && head[24]) begin pop = 1; col = head[23:0]; f_s = 1; end
                else if (org) m_mode = 1;
                else if (head[24]) m_mode = 2;
                else begin pop = 1; col = head[23:0]; end
            end
            if (uf_set) m_o.uf = 1'b1; else if (clr) m_o.uf = 1'b0;
            if (tick) begin
                m_o.rgb = col;
                m_o.hs  = (h >= T_HA + T_HF && h < T_HA + T_HF + T_HS) ? T_HPOL : !T_HPOL;
                m_o.vs  = (v >= T_VA + T_VF && v < T_VA + T_VF + T_VS) ? T_VPOL : !T_VPOL;
                m_o.fs  = f_s;
            end else begin
                m_o.fs = 1'b0;
            end
            if (pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back({sop, data});
            m_clk++;
        end
        m_o.rdy = (m_q.size() < T_DEPTH) && en && rstn;
    endtask

    task automatic step();
        obs_t got;
        model_eval();
        @(posedge clk);
        #1;
        got = {r, g, b, hs, vs, fs, uf, rdy};
        n_vec++;
        if (got !== m_o) begin
            n_bad++;
            $display("FAIL model t=%0t got rgb=%h hs=%b vs=%b fs=%b uf=%b rdy=%b exp rgb=%h hs=%b vs=%b fs=%b uf=%b rdy=%b",
                     $time, got.rgb, got.hs, got.vs, got.fs, got.uf, got.rdy,
                     m_o.rgb, m_o.hs, m_o.vs, m_o.fs, m_o.uf, m_o.rdy);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, act_v, exp_v);
        end
    endtask

    task automatic check_reset_pins(input string name);
        chk({name, "_rgb"}, {8'h0, r, g, b}, 32'h0);
        chk({name, "_sync"}, {30'h0, hs, vs}, {30'h0, !T_HPOL, !T_VPOL});
        chk({name, "_flags"}, {29'h0, fs, uf, rdy}, 32'h0);
    endtask

    // Streams a case's words as fast as the FIFO accepts them and compares
    // the active pixels of the first two frames against the table.
    task automatic run_case(input case_t c, input bit do_rst);
        int wi, p, f, h, v, idx, n, st;
        logic [23:0] expc;
        bit expfs;
        valid = 0; sop = 0; clr = 0; data = '0;
        if (do_rst) begin
            rstn = 0; en = 0; step(); step();
            rstn = 1; step();
        end
        rstn = 1; en = 1; wi = 0;
        for (int k = 0; k <= 192; k++) begin
            if (wi < c.n_words && !(wi >= c.hold_at && k < 2 * c.rel_pos)) begin
                valid = 1; sop = c.sop_mask[wi]; data = wdata(wi);
            end else begin
                valid = 0; sop = 0;
            end
            step();
            if (m_push) wi++;
            if (k >= 2 && (k % 2) == 0) begin
                p = (k - 2) / 2;
                f = p / (T_HT * T_VT);
                h = p % T_HT;
                v = (p / T_HT) % T_VT;
                if (h < T_HA && v < T_VA) begin
                    idx   = v * T_HA + h;
                    n     = (f == 0) ? c.f0_n : c.f1_n;
                    st    = (f == 0) ? c.f0_start : c.f1_start;
                    expc  = (idx < n) ? wdata(st + idx) : T_FILL;
                    expfs = (idx == 0) && (n > 0);
                    chk($sformatf("table_f%0d_px%0d", f, idx), {7'h0, r, g, b, fs}, {7'h0, expc, expfs});
                end
            end
        end
        valid = 0;
        chk("table_underflow", {31'h0, uf}, {31'h0, c.exp_uf});
    endtask

    case_t cases[4];
    int    prob;
    int    fidx;

    initial begin
        //              words sop_mask  hold rel  f0s f0n f1s f1n uf
        cases[0] = '{24, 32'h1001, 99, 0,  0, 12, 12, 12, 1'b0};  // two ordered frames
        cases[1] = '{22, 32'h0401, 10, 24, 0, 10, 10, 12, 1'b1};  // short frame underflows
        cases[2] = '{27, 32'h8008, 99, 0,  0, 0,  3,  12, 1'b0};  // junk before sop
        cases[3] = '{17, 32'h0021, 99, 0,  0, 5,  5,  12, 1'b0};  // early sop at index 5

        rstn = 0; en = 0; valid = 0; sop = 0; clr = 0; data = '0;
        step(); step();
        check_reset_pins("reset");

        run_case(cases[0], 1'b1);
        valid = 0;
        repeat (16) step();
        en = 0; step();
        check_reset_pins("enable_drop");
        run_case(cases[0], 1'b0);

        repeat (16) step();
        rstn = 0; step();
        check_reset_pins("reset_midframe");
        run_case(cases[1], 1'b0);

        clr = 1; step();
        chk("underflow_clr", {31'h0, uf}, 32'h0);
        step();
        chk("underflow_set_wins", {31'h0, uf}, 32'h1);
        clr = 0;

        run_case(cases[2], 1'b1);
        run_case(cases[3], 1'b1);

        // Randomised traffic: frames of 12 words with occasional early sop,
        // bursty valid, random clears, enable drops and resets.
        fidx = 0; prob = 50; rstn = 1; en = 1;
        for (int k = 0; k < 6000; k++) begin
            if (k % 150 == 0) begin
                case ($urandom_range(0, 2))
                    0:       prob = 3;
                    1:       prob = 40;
                    default: prob = 95;
                endcase
            end
            rstn  = ($urandom % 800) != 0;
            if (($urandom % 600) == 0)            en = 0;
            else if (!en && ($urandom % 4) == 0)  en = 1;
            clr   = ($urandom % 50) == 0;
            valid = ($urandom % 100) < prob;
            sop   = (fidx == 0);
            data  = 24'($urandom);
            step();
            if (m_push) fidx = (($urandom % 40) == 0) ? 0 : (fidx + 1) % 12;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
